// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one memory line port between
// the icache read path and the dcache read/write-back path.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   i_read, i_addr                icache line read request
//   i_rdata, i_resp               icache line data + completion pulse
//   d_read, d_write, d_addr       dcache fill / write-back request
//   d_wdata                       dcache write-back data
//   d_rdata, d_resp               dcache line data + completion pulse
//   mem_read, mem_write           memory strobes, held per transaction
//   mem_addr, mem_wdata           registered memory address / data
//   mem_rdata, mem_resp           memory read data + completion pulse
module mem_arbiter #(
    parameter int s_addr = 32,
    parameter int s_line = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [s_addr-1:0] i_addr,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_addr-1:0] d_addr,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [s_addr-1:0] mem_addr,
    output logic [s_line-1:0] mem_wdata,
    input  logic [s_line-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR
    } state_t;

    state_t state;
    state_t next_state;

    // set when the dcache received the most recent grant
    logic   last_d;
    logic   grant_i;
    logic   grant_d;
    logic   d_req;

    assign d_req = d_read | d_write;

    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        unique case (state)
            IDLE: begin
                // contention goes to whoever was not served last
                if (i_read && (!d_req || last_d)) begin
                    grant_i    = 1'b1;
                    next_state = I_RD;
                end else if (d_req) begin
                    grant_d    = 1'b1;
                    // write wins if a client drives both
                    next_state = d_write ? D_WR : D_RD;
                end
            end
            I_RD: begin
                if (mem_resp) begin
                    i_resp     = 1'b1;
                    next_state = IDLE;
                end
            end
            D_RD, D_WR: begin
                if (mem_resp) begin
                    d_resp     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= next_state;
            // strobes come straight from flops so they cannot glitch
            mem_read  <= (next_state == I_RD) || (next_state == D_RD);
            mem_write <= (next_state == D_WR);
            if (grant_i) begin
                mem_addr <= i_addr;
                last_d   <= 1'b0;
            end
            if (grant_d) begin
                mem_addr <= d_addr;
                last_d   <= 1'b1;
                if (d_write) begin
                    mem_wdata <= d_wdata;
                end
            end
        end
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized bench for mem_arbiter
// with a transaction-level arbitration model.
module tb_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    mem_arbiter #(.s_addr(32), .s_line(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // traffic controls
    bit ci_en, cd_en, scramble, mem_en, use_pat;
    int i_pct, d_pct, stray_pct, fix_dly;
    logic [255:0] pat;

    // client / memory responder state
    bit i_done, d_done, mbusy;
    int mwait;
    int n_ir, n_dr;

    // reference model: who owns the port, who was served last
    int m_owner;   // 0 none, 1 icache, 2 dcache
    int m_last;    // 1 icache, 2 dcache
    bit m_wr;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;
    int m_ci, m_cd;
    int glog[$];

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        a[4:0] = 5'd0;
        return a;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_last  = 1;
        m_wr    = 1'b0;
        i_done  = 1'b0;
        d_done  = 1'b0;
        mbusy   = 1'b0;
        mwait   = 0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        i_read   = 1'b0;
        d_read   = 1'b0;
        d_write  = 1'b0;
        mem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_resp", i_resp, 0);
        chk("rst_d_resp", d_resp, 0);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive at edge+1, check combinational at edge+2,
    // advance model, check registered outputs at next edge+1.
    task automatic cyc();
        int r;
        bit wi, wd;
        if (i_done) begin
            i_read = 1'b0;
            i_done = 1'b0;
        end else if (!i_read && ci_en && $urandom_range(99) < i_pct) begin
            i_read = 1'b1;
            i_addr = rnd_addr();
        end
        if (d_done) begin
            d_read  = 1'b0;
            d_write = 1'b0;
            d_done  = 1'b0;
        end else if (!(d_read || d_write) && cd_en &&
                     $urandom_range(99) < d_pct) begin
            r       = $urandom_range(9);
            d_write = (r < 4) || (r == 9);
            d_read  = (r >= 4);
            d_addr  = rnd_addr();
            d_wdata = rnd_line();
        end
        if (scramble && m_owner == 1) i_addr = rnd_addr();
        if (scramble && m_owner == 2) begin
            d_addr  = rnd_addr();
            d_wdata = rnd_line();
        end
        mem_resp  = 1'b0;
        mem_rdata = use_pat ? pat : rnd_line();
        if (mem_read || mem_write) begin
            if (!mbusy) begin
                mbusy = 1'b1;
                mwait = (fix_dly >= 0) ? fix_dly : int'($urandom_range(3));
            end
            if (mwait == 0) begin
                if (mem_en) begin
                    mem_resp = 1'b1;
                    mbusy    = 1'b0;
                end
            end else begin
                mwait--;
            end
        end else if (mem_en && $urandom_range(99) < stray_pct) begin
            mem_resp = 1'b1;
        end
        #1;
        chk("i_resp", i_resp, (m_owner == 1) && mem_resp);
        chk("d_resp", d_resp, (m_owner == 2) && mem_resp);
        chk("resp_excl", i_resp && d_resp, 0);
        if (i_resp) begin
            chk("i_rdata", i_rdata, mem_rdata);
            n_ir++;
            i_done = 1'b1;
        end
        if (d_resp) begin
            chk("d_rdata", d_rdata, mem_rdata);
            n_dr++;
            d_done = 1'b1;
        end
        if (m_owner != 0) begin
            if (mem_resp) begin
                if (m_owner == 1) m_ci++;
                else m_cd++;
                m_owner = 0;
            end
        end else begin
            wi = i_read;
            wd = d_read || d_write;
            if (wi && (!wd || m_last == 2)) begin
                m_owner = 1;
                m_last  = 1;
                m_addr  = i_addr;
                m_wr    = 1'b0;
                glog.push_back(1);
            end else if (wd) begin
                m_owner = 2;
                m_last  = 2;
                m_addr  = d_addr;
                m_wr    = d_write;
                if (d_write) m_wdata = d_wdata;
                glog.push_back(2);
            end
        end
        @(posedge clk);
        #1;
        chk("mem_read", mem_read, (m_owner != 0) && !m_wr);
        chk("mem_write", mem_write, (m_owner != 0) && m_wr);
        if (m_owner != 0) begin
            chk("mem_addr", mem_addr, m_addr);
            if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    initial begin
        int si, sd;
        logic [255:0] pat_b;
        ci_en = 0; cd_en = 0; scramble = 0; mem_en = 1; use_pat = 0;
        i_pct = 0; d_pct = 0; stray_pct = 0; fix_dly = -1;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        n_ir = 0; n_dr = 0; m_ci = 0; m_cd = 0;
        model_reset();
        do_reset();

        // icache alone, 5-cycle memory latency, fixed data pattern
        pat     = rnd_line();
        use_pat = 1;
        fix_dly = 5;
        i_read  = 1'b1;
        i_addr  = 32'h0000_1040;
        cyc();
        chk("t1_strobe_latency", mem_read, 1);
        chk("t1_mem_addr", mem_addr, 32'h0000_1040);
        repeat (9) cyc();
        chk("t1_i_resp_count", n_ir, 1);
        chk("t1_d_resp_count", n_dr, 0);
        use_pat = 0;

        // dcache write-back then fill; client wiggles d_addr while busy
        pat_b    = rnd_line();
        fix_dly  = 2;
        scramble = 1;
        d_write  = 1'b1;
        d_addr   = 32'h0000_2000;
        d_wdata  = pat_b;
        repeat (2) cyc();
        chk("t2_mem_write", mem_write, 1);
        chk("t2_mem_wdata", mem_wdata, pat_b);
        chk("t2_mem_addr", mem_addr, 32'h0000_2000);
        repeat (6) cyc();
        chk("t2_wb_resp", n_dr, 1);
        scramble = 0;
        d_read   = 1'b1;
        d_addr   = 32'h0000_3000;
        cyc();
        chk("t2_fill_addr", mem_addr, 32'h0000_3000);
        repeat (7) cyc();
        chk("t2_fill_resp", n_dr, 2);

        // simultaneous requests from reset: dcache first
        do_reset();
        glog.delete();
        fix_dly = 1;
        i_read  = 1'b1;
        i_addr  = 32'h0000_4000;
        d_read  = 1'b1;
        d_addr  = 32'h0000_5000;
        repeat (12) cyc();
        chk("t3_grants", glog.size(), 2);
        chk("t3_first_d", glog[0], 2);
        chk("t3_second_i", glog[1], 1);

        // both clients hammering: grants must alternate
        glog.delete();
        fix_dly = -1;
        ci_en = 1; cd_en = 1; i_pct = 100; d_pct = 100;
        for (int c = 0; c < 400 && glog.size() < 21; c++) cyc();
        chk("t4_enough_grants", glog.size() >= 21, 1);
        for (int k = 1; k < 21 && k < glog.size(); k++)
            chk("t4_alternate", glog[k] != glog[k-1], 1);
        ci_en = 0; cd_en = 0;
        repeat (12) cyc();

        // reset while a dcache fill is in flight
        si = n_ir;
        sd = n_dr;
        mem_en = 0;
        d_read = 1'b1;
        d_addr = 32'h0000_6000;
        repeat (3) cyc();
        chk("t5_busy", mem_read, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_read", mem_read, 0);
        chk("t5_async_addr", mem_addr, 0);
        chk("t5_no_d_resp", d_resp, 0);
        d_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        mem_en = 1;
        i_read = 1'b1;
        i_addr = 32'h0000_7000;
        repeat (10) cyc();
        chk("t5_i_served", n_ir, si + 1);
        chk("t5_d_abandoned", n_dr, sd);

        // stray mem_resp in IDLE, then write-back with scrambled client
        si = n_ir;
        sd = n_dr;
        stray_pct = 100;
        repeat (4) cyc();
        chk("t6_stray_i", n_ir, si);
        chk("t6_stray_d", n_dr, sd);
        scramble = 1;
        fix_dly  = 3;
        d_write  = 1'b1;
        d_addr   = 32'h0000_8000;
        d_wdata  = rnd_line();
        repeat (8) cyc();
        chk("t6_wb_done", n_dr, sd + 1);
        stray_pct = 0;

        // randomized mixed traffic
        fix_dly = -1; stray_pct = 20;
        ci_en = 1; cd_en = 1; i_pct = 30; d_pct = 30;
        repeat (800) cyc();
        ci_en = 0; cd_en = 0; stray_pct = 0;
        repeat (20) cyc();
        chk("rnd_i_count", n_ir, m_ci);
        chk("rnd_d_count", n_dr, m_cd);
        chk("rnd_idle_read", i_read, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
